// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding and slice constants for the nibble-serial subtractor
package sub_pkg;
  localparam int SLICE = 4;
  localparam int NSLICE = 16 / SLICE;
  localparam int IDX_W = $clog2(NSLICE);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sub4bit.sv
// sub4bit: 4-bit borrow-lookahead slice d = a - b - bin; ports a, b, bin in; d, p, g, bout out
module sub4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       p,
  output logic       g,
  output logic       bout
);
  logic [3:0] pi, gi, c;
  logic cin;
  assign cin = ~bin;
  assign pi = a ^ ~b;
  assign gi = a & ~b;
  assign c[0] = cin;
  assign c[1] = gi[0] | pi[0] & cin;
  assign c[2] = gi[1] | pi[1] & gi[0] | pi[1] & pi[0] & cin;
  assign c[3] = gi[2] | pi[2] & gi[1] | pi[2] & pi[1] & gi[0] | pi[2] & pi[1] & pi[0] & cin;
  assign d = pi ^ c;
  assign p = &pi;
  assign g = gi[3] | pi[3] & gi[2] | pi[3] & pi[2] & gi[1] | pi[3] & pi[2] & pi[1] & gi[0];
  assign bout = ~(g | p & cin);
endmodule

// File: rtl/sub16_serial.sv
// sub16_serial: nibble-serial d = a - b - bin with valid/ready handshakes; ports clk, reset, in_valid/in_ready/a/b/bin in, out_valid/out_ready/d/bout/zero/ovf out
module sub16_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  import sub_pkg::*;
  localparam int NS = WIDTH / SLICE;
  localparam int M = WIDTH - 1;
  state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] ra, rb, d_nx;
  logic borrow, last, s_p, s_g, s_bout;
  logic [SLICE-1:0] s_d;
  sub4bit u_slice (
    .a(ra[idx*SLICE +: SLICE]),
    .b(rb[idx*SLICE +: SLICE]),
    .bin(borrow),
    .d(s_d),
    .p(s_p),
    .g(s_g),
    .bout(s_bout)
  );
  assign last = idx == IDX_W'(NS - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    d_nx = d;
    d_nx[idx*SLICE +: SLICE] = s_d;
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
                               (out_ready ? IDLE : DONE);
  end
  // borrow holds bin for slice 0, then the previous slice's borrow-out
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      d <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      ovf <= 1'b0;
      borrow <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        ra <= a;
        rb <= b;
        borrow <= bin;
        idx <= '0;
      end
      if (state == RUN) begin
        d <= d_nx;
        borrow <= s_bout;
        idx <= idx + IDX_W'(1);
        if (last) begin
          bout <= ~(s_g | s_p & ~borrow);
          zero <= d_nx == '0;
          ovf <= (ra[M] != rb[M]) && (d_nx[M] != ra[M]);
        end
      end
    end
  end
endmodule

// File: tb/tb_sub16_serial.sv
// tb_sub16_serial: directed self-checking bench with an arithmetic reference model
module tb_sub16_serial;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic in_ready, out_valid, bout, zero, ovf;
  logic [15:0] d;
  int n_cmp = 0, n_fail = 0;
  logic have_exp = 1'b0;
  logic [15:0] exp_d;
  logic exp_b, exp_z, exp_o;

  sub16_serial dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic void model(input logic [15:0] ma, mb, input logic mbin,
                                output logic [15:0] md, output logic mbo, mz, mo);
    int u, s;
    u = int'(ma) - int'(mb) - int'(mbin);
    s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    md = u[15:0];
    mbo = u < 0;
    mz = u[15:0] == 16'h0;
    mo = s > 32767 || s < -32768;
  endfunction

  always @(negedge clk)
    if (!reset && out_valid) begin
      if (!have_exp) chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      else begin
        chk("cmp_d", {16'b0, d}, {16'b0, exp_d});
        chk("cmp_bout", {31'b0, bout}, {31'b0, exp_b});
        chk("cmp_zero", {31'b0, zero}, {31'b0, exp_z});
        chk("cmp_ovf", {31'b0, ovf}, {31'b0, exp_o});
      end
    end

  task automatic do_op(input logic [15:0] ta, tb, input logic tbin,
                       input logic [15:0] ld, input logic lb, lz, lo, input bit hold);
    int lat;
    model(ta, tb, tbin, exp_d, exp_b, exp_z, exp_o);
    chk("model_d", {16'b0, exp_d}, {16'b0, ld});
    chk("model_flags", {29'b0, exp_b, exp_z, exp_o}, {29'b0, lb, lz, lo});
    @(negedge clk);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1; have_exp = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    chk("latency", lat, 4);
    chk("lit_d", {16'b0, d}, {16'b0, ld});
    chk("lit_flags", {29'b0, bout, zero, ovf}, {29'b0, lb, lz, lo});
    if (hold) begin
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0000; bin = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_d", {16'b0, d}, {16'b0, ld});
      end
      @(negedge clk) in_valid = 1'b0;
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    have_exp = 1'b0;
    chk("in_ready_after", {31'b0, in_ready}, 32'd1);
    chk("out_valid_after", {31'b0, out_valid}, 32'd0);
    chk("d_held_after", {16'b0, d}, {16'b0, ld});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_d", {16'b0, d}, 32'd0);
    chk("rst_flags", {29'b0, bout, zero, ovf}, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    do_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h0E1E, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_d", {16'b0, d}, 32'd0);
    chk("abort_flags", {29'b0, bout, zero, ovf}, 32'd0);
    reset = 1'b0;
    do_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
